note_sequencer: RTL and testbench

//  Buffered melody player for the note display. Accepts queued notes and plays

---
 rtl/note_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Buffered melody player: a small note FIFO feeding a playback FSM that drives
// the 7-segment letter, tone indicator and playing flag.
module note_sequencer #(
   parameter int DEPTH    = 8,
   parameter int DUR_W    = 4,
   parameter int TICK_DIV = 4,
   parameter int GAP_CYC  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2:0]                   in_note,
   input  logic                         in_low,
   input  logic [DUR_W-1:0]             in_dur,
   output logic [6:0]                   seg,
   output logic                         tone_low,
   output logic                         playing,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   // state  | meaning
   // S_IDLE | nothing sounding; waits for a queued note
   // S_PLAY | current note shown for max(dur,1)*TICK_DIV cycles
   // S_GAP  | blank for GAP_CYC cycles between notes

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC+1) : 1;
   localparam int EW = 4 + DUR_W;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   function automatic logic [6:0] seg_code(input logic [2:0] n);
      logic [6:0] s;
      case (n)
         3'd1:    s = 7'b1110111;
         3'd2:    s = 7'b1111100;
         3'd3:    s = 7'b0111001;
         3'd4:    s = 7'b1011110;
         3'd5:    s = 7'b1111001;
         3'd6:    s = 7'b1110001;
         3'd7:    s = 7'b0111101;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   state_t           state_q, state_d;
   logic [6:0]       seg_q, seg_d;
   logic             tone_q, tone_d;
   logic             playing_q, playing_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [GW-1:0]    gap_q, gap_d;

   logic             push, pop, load, go_idle, end_note;
   logic [EW-1:0]    head;
   logic [2:0]       head_note;
   logic             head_low;
   logic [DUR_W-1:0] head_dur;

   assign in_ready  = (count_q != CW'(DEPTH)) && !rst;
   assign push      = in_valid && in_ready && !flush;
   assign head      = mem_q[rd_ptr_q];
   assign head_note = head[EW-1 -: 3];
   assign head_low  = head[DUR_W];
   assign head_dur  = head[DUR_W-1:0];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_note, in_low, in_dur};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      seg_d     = seg_q;
      tone_d    = tone_q;
      playing_d = playing_q;
      dur_d     = dur_q;
      pre_d     = pre_q;
      gap_d     = gap_q;
      pop       = 1'b0;
      load      = 1'b0;
      go_idle   = 1'b0;
      end_note  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) load = 1'b1;
         end
         S_PLAY: begin
            if (pre_q == PW'(TICK_DIV-1)) begin
               pre_d = '0;
               if (dur_q == DUR_W'(1)) end_note = 1'b1;
               else                    dur_d    = dur_q - DUR_W'(1);
            end else begin
               pre_d = pre_q + PW'(1);
            end
            if (end_note) begin
               if (GAP_CYC > 0) begin
                  state_d = S_GAP;
                  seg_d   = '0;
                  tone_d  = 1'b0;
                  gap_d   = GW'(GAP_CYC);
               end else if (count_q != '0) begin
                  load = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q <= GW'(1)) begin
               if (count_q != '0) load    = 1'b1;
               else               go_idle = 1'b1;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: go_idle = 1'b1;
      endcase

      // A zero duration plays as a single tick so every note is visible.
      if (load) begin
         pop       = 1'b1;
         state_d   = S_PLAY;
         seg_d     = seg_code(head_note);
         tone_d    = head_low;
         playing_d = 1'b1;
         dur_d     = (head_dur == '0) ? DUR_W'(1) : head_dur;
         pre_d     = '0;
      end
      if (go_idle) begin
         state_d   = S_IDLE;
         seg_d     = '0;
         tone_d    = 1'b0;
         playing_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= S_IDLE;
         seg_q     <= '0;
         tone_q    <= 1'b0;
         playing_q <= 1'b0;
         dur_q     <= '0;
         pre_q     <= '0;
         gap_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         seg_q     <= seg_d;
         tone_q    <= tone_d;
         playing_q <= playing_d;
         dur_q     <= dur_d;
         pre_q     <= pre_d;
         gap_q     <= gap_d;
      end
   end

   // Note storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign seg      = seg_q;
   assign tone_low = tone_q;
   assign playing  = playing_q;
   assign count    = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at default parameters (TICK_DIV=4, GAP_CYC=1).
module tb_note_sequencer;

   localparam logic [6:0] SEG_0 = 7'b0000000;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b1111100;
   localparam logic [6:0] SEG_C = 7'b0111001;
   localparam logic [6:0] SEG_D = 7'b1011110;
   localparam logic [6:0] SEG_E = 7'b1111001;
   localparam logic [6:0] SEG_F = 7'b1110001;
   localparam logic [6:0] SEG_G = 7'b0111101;

   logic       clk, rst, flush, in_valid, in_ready, in_low;
   logic [2:0] in_note;
   logic [3:0] in_dur;
   logic [6:0] seg;
   logic       tone_low, playing;
   logic [3:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   note_sequencer #(.DEPTH(8), .DUR_W(4), .TICK_DIV(4), .GAP_CYC(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_note(in_note), .in_low(in_low), .in_dur(in_dur),
      .seg(seg), .tone_low(tone_low), .playing(playing), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] n, input logic l, input logic [3:0] d);
      in_valid = 1'b1;
      in_note  = n;
      in_low   = l;
      in_dur   = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic span(input string tag, input logic [6:0] s, input logic t,
                       input logic p, input int n, input bit ct);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(tag, {24'h0, p, s} , {24'h0, playing, seg} === {p, s} ? {24'h0, p, s} : {24'h0, playing, seg});
         if (ct) chk({tag, "_tone"}, tone_low, t);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!playing && count == 0) break;
         @(negedge clk);
      end
      chk("idle_reached", {playing, count}, 5'h0);
   endtask

   logic [6:0] got_q[$];
   logic [6:0] exp_q[$];
   logic [6:0] prev, acc_seg;
   logic       took, acc_play;
   int         notes_at_acc, cnt_at_acc;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_note = 3'd0; in_low = 1'b0; in_dur = 4'd0;

      // reset
      @(negedge clk); @(negedge clk);
      chk("rst_seg", seg, SEG_0);
      chk("rst_tone", tone_low, 1'b0);
      chk("rst_play", playing, 1'b0);
      chk("rst_count", count, 4'd0);
      chk("rst_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("rel_ready", in_ready, 1'b1);

      // single note A, high tone, 2 ticks
      push(3'd1, 1'b0, 4'd2);
      chk("one_count", count, 4'd1);
      chk("one_seg0", seg, SEG_0);
      span("one_a", SEG_A, 1'b0, 1'b1, 8, 1'b1);
      span("one_gap", SEG_0, 1'b0, 1'b1, 1, 1'b1);
      span("one_idle", SEG_0, 1'b0, 1'b0, 2, 1'b1);

      // back-to-back d(low,1) then G(high,3)
      push(3'd4, 1'b1, 4'd1);
      push(3'd7, 1'b0, 4'd3);
      chk("b2b_d0", {tone_low, seg}, {1'b1, SEG_D});
      span("b2b_d", SEG_D, 1'b1, 1'b1, 3, 1'b1);
      span("b2b_gap1", SEG_0, 1'b0, 1'b1, 1, 1'b1);
      span("b2b_g", SEG_G, 1'b0, 1'b1, 12, 1'b1);
      span("b2b_gap2", SEG_0, 1'b0, 1'b1, 1, 1'b1);
      span("b2b_idle", SEG_0, 1'b0, 1'b0, 1, 1'b1);

      // rest then E with zero durations
      push(3'd0, 1'b1, 4'd0);
      push(3'd5, 1'b1, 4'd0);
      chk("edge_rest0", {playing, seg}, {1'b1, SEG_0});
      span("edge_rest", SEG_0, 1'b0, 1'b1, 3, 1'b0);
      span("edge_gap1", SEG_0, 1'b0, 1'b1, 1, 1'b1);
      span("edge_e", SEG_E, 1'b1, 1'b1, 4, 1'b1);
      span("edge_gap2", SEG_0, 1'b0, 1'b1, 1, 1'b1);
      span("edge_idle", SEG_0, 1'b0, 1'b0, 1, 1'b1);
      wait_idle();

      // fill the FIFO behind a long C, then a stalled 10th push
      push(3'd3, 1'b0, 4'd15);
      push(3'd1, 1'b0, 4'd1); push(3'd2, 1'b0, 4'd1);
      push(3'd3, 1'b0, 4'd1); push(3'd4, 1'b0, 4'd1);
      push(3'd5, 1'b0, 4'd1); push(3'd6, 1'b0, 4'd1);
      push(3'd7, 1'b0, 4'd1); push(3'd1, 1'b0, 4'd1);
      chk("full_count", count, 4'd8);
      chk("full_ready", in_ready, 1'b0);
      exp_q = '{SEG_C, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_A, SEG_B};
      got_q.delete();
      prev = SEG_0; took = 1'b0; notes_at_acc = -1; cnt_at_acc = -1;
      in_valid = 1'b1; in_note = 3'd2; in_low = 1'b0; in_dur = 4'd1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (seg != SEG_0 && prev == SEG_0) got_q.push_back(seg);
         prev = seg;
         if (in_valid) begin
            if (took) in_valid = 1'b0;
            else if (in_ready) begin
               took = 1'b1;
               notes_at_acc = got_q.size();
               cnt_at_acc = int'(count);
            end
         end
         if (!playing && count == 0 && !in_valid) break;
      end
      in_valid = 1'b0;
      chk("full_done", {playing, count}, 5'h0);
      chk("stall_notes", notes_at_acc, 2);
      chk("stall_count", cnt_at_acc, 7);
      chk("full_n", got_q.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < got_q.size()) chk($sformatf("full_note%0d", i), got_q[i], exp_q[i]);
      end

      // flush during the second of three notes, with a same-cycle push
      push(3'd1, 1'b0, 4'd1);
      push(3'd2, 1'b1, 4'd2);
      push(3'd3, 1'b0, 4'd1);
      for (int i = 0; i < 50; i++) begin
         if (seg == SEG_B) break;
         @(negedge clk);
      end
      chk("fl_reach", seg, SEG_B);
      @(negedge clk); @(negedge clk);
      chk("fl_pending", count, 4'd1);
      flush = 1'b1;
      in_valid = 1'b1; in_note = 3'd7; in_low = 1'b0; in_dur = 4'd1;
      #1;
      chk("fl_ready_live", in_ready, 1'b1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_blank", {playing, tone_low, seg}, 9'h0);
      chk("fl_count", count, 4'd0);
      acc_seg = SEG_0; acc_play = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         acc_seg  = acc_seg | seg;
         acc_play = acc_play | playing;
      end
      chk("fl_never", {acc_play, acc_seg}, 8'h0);

      // reset mid-note
      push(3'd5, 1'b1, 4'd3);
      @(negedge clk); @(negedge clk);
      chk("rs_mid_seg", seg, SEG_E);
      rst = 1'b1;
      @(negedge clk);
      chk("rs_blank", {playing, tone_low, seg}, 9'h0);
      chk("rs_count", count, 4'd0);
      chk("rs_ready", in_ready, 1'b0);
      rst = 1'b0;
      acc_seg = SEG_0; acc_play = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc_seg  = acc_seg | seg;
         acc_play = acc_play | playing;
      end
      chk("rs_never", {acc_play, acc_seg}, 8'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
